// File: rtl/fidv_pkg.sv
// Shared types and constants for the fixed-point divider verification helpers:
// default width, reconstruction FSM states, and op/rounding encodings.
package fidv_pkg;

    localparam int FIDV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } fidv_recon_state_t;

    // Op encoding matches the divider's reconstruct/product selector
    typedef enum logic {
        OP_RECON   = 1'b0,
        OP_PRODUCT = 1'b1
    } fidv_op_t;

    typedef enum logic [1:0] {
        RND_TRUNC   = 2'd0,
        RND_FLOOR   = 2'd1,
        RND_CEIL    = 2'd2,
        RND_NEAREST = 2'd3
    } fidv_rnd_t;

endpackage

// File: rtl/fidv_recon_if.sv
// Operand/result handshake bundle for fidv_recon; master drives operands and
// out_ready, slave (the reconstructor) drives in_ready and the result.
interface fidv_recon_if
    import fidv_pkg::*;
#(
    parameter int WIDTH = FIDV_WIDTH_DEFAULT
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     Q;
    logic [WIDTH-1:0]     D;
    logic [WIDTH-1:0]     R;
    logic                 op;
    logic [2*WIDTH-1:0]   N_exp;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   N;
    logic                 rem_err;
    logic                 mismatch;

    modport master (
        output in_valid, Q, D, R, op, N_exp, out_ready,
        input  in_ready, out_valid, N, rem_err, mismatch
    );

    modport slave (
        input  in_valid, Q, D, R, op, N_exp, out_ready,
        output in_ready, out_valid, N, rem_err, mismatch
    );

endinterface

// File: rtl/fidv_mac_step.sv
// One radix-2 shift-add multiply step: conditionally accumulate the shifted
// multiplicand on the multiplier LSB, then advance both operands by one bit.
module fidv_mac_step
    import fidv_pkg::*;
#(
    parameter int WIDTH = FIDV_WIDTH_DEFAULT
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    assign acc_next    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_next  = mcand << 1;
    assign mplier_next = mplier >> 1;

endmodule

// File: rtl/fidv_recon.sv
// Numerator reconstructor N = Q*D (+ R) for divider self-checking, built as a
// bit-serial multiplier FSM. Optional N_exp comparison: FIDV_RECON_CHECK_EN.
module fidv_recon
    import fidv_pkg::*;
#(
    parameter int WIDTH = FIDV_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fidv_recon_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    fidv_recon_state_t  state;
    logic [CW-1:0]      step_cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   d_cap;
    logic [WIDTH-1:0]   r_cap;
    fidv_op_t           op_cap;

    logic               idle_rdy;
    logic               res_vld;
    logic [2*WIDTH-1:0] res_n;
    logic               res_rem_err;

    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand_next;
    logic [WIDTH-1:0]   mplier_next;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;

    fidv_mac_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    // Product-only mode skips the remainder term; the sum can never overflow 2*WIDTH bits
    assign addend = (op_cap == OP_RECON) ? {{WIDTH{1'b0}}, r_cap} : '0;
    assign sum    = acc + addend;

`ifdef FIDV_RECON_CHECK_EN
    logic [2*WIDTH-1:0] nexp_cap;
    logic               res_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            nexp_cap     <= '0;
            res_mismatch <= 1'b0;
        end else if (state == IDLE && idle_rdy && bus.in_valid) begin
            nexp_cap     <= bus.N_exp;
        end else if (state == ADD) begin
            res_mismatch <= (sum != nexp_cap);
        end
    end

    assign bus.mismatch = res_mismatch;
`else
    logic unused_nexp;
    assign unused_nexp  = ^bus.N_exp;
    assign bus.mismatch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step_cnt    <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            d_cap       <= '0;
            r_cap       <= '0;
            op_cap      <= OP_RECON;
            idle_rdy    <= 1'b1;
            res_vld     <= 1'b0;
            res_n       <= '0;
            res_rem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_rdy && bus.in_valid) begin
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, bus.D};
                        mplier   <= bus.Q;
                        d_cap    <= bus.D;
                        r_cap    <= bus.R;
                        op_cap   <= fidv_op_t'(bus.op);
                        step_cnt <= '0;
                        idle_rdy <= 1'b0;
                        state    <= MUL;
                    end
                end
                // Always WIDTH steps, even when the multiplier runs out of ones early
                MUL: begin
                    acc      <= acc_next;
                    mcand    <= mcand_next;
                    mplier   <= mplier_next;
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    res_n       <= sum;
                    res_rem_err <= (r_cap >= d_cap);
                    state       <= DONE;
                end
                // First DONE cycle raises out_valid; the result then holds until taken
                DONE: begin
                    if (!res_vld) begin
                        res_vld <= 1'b1;
                    end else if (bus.out_ready) begin
                        res_vld  <= 1'b0;
                        idle_rdy <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    idle_rdy <= 1'b1;
                    res_vld  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = idle_rdy;
    assign bus.out_valid = res_vld;
    assign bus.N         = res_n;
    assign bus.rem_err   = res_rem_err;

endmodule

// File: tb/tb_fidv_recon.sv
// Scoreboard bench for fidv_recon at WIDTH=32: directed vectors, latency,
// backpressure, busy-ignore, mid-operation reset and random transactions.
module tb_fidv_recon;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct {
        logic [2*W-1:0] n;
        logic           rem;
        logic           mm;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    fidv_recon_if #(.WIDTH(W)) bus ();

    fidv_recon #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: plain wide arithmetic on the operands
    function automatic exp_t model(input logic [W-1:0] q, input logic [W-1:0] d,
                                   input logic [W-1:0] r, input logic o,
                                   input logic [2*W-1:0] nexp);
        exp_t e;
        logic [2*W-1:0] prod;
        prod  = {{W{1'b0}}, q} * {{W{1'b0}}, d};
        e.n   = o ? prod : prod + {{W{1'b0}}, r};
        e.rem = (r >= d);
`ifdef FIDV_RECON_CHECK_EN
        e.mm  = (e.n != nexp);
`else
        e.mm  = 1'b0;
`endif
        return e;
    endfunction

    task automatic send(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                        input logic o, input logic [2*W-1:0] nexp);
        int g;
        g = 0;
        while (!bus.in_ready && g < 200) begin
            tick();
            g++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.Q        = q;
        bus.D        = d;
        bus.R        = r;
        bus.op       = o;
        bus.N_exp    = nexp;
        bus.in_valid = 1'b1;
        sb.push_back(model(q, d, r, o, nexp));
        tick();
        bus.in_valid = 1'b0;
    endtask

    // exp_lat < 0 skips the latency check; hold = cycles of out_ready=0 backpressure
    task automatic collect(input int exp_lat, input int hold);
        int   lat;
        exp_t e;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("out_valid_seen", bus.out_valid, 1);
        if (exp_lat >= 0) check("latency", lat, exp_lat);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb[0];
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_N", bus.N, e.n);
                check("hold_out_valid", bus.out_valid, 1);
                check("hold_in_ready", bus.in_ready, 0);
            end
            e = sb.pop_front();
            check("N", bus.N, e.n);
            check("rem_err", bus.rem_err, e.rem);
            check("mismatch", bus.mismatch, e.mm);
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check("post_out_valid", bus.out_valid, 0);
            check("post_in_ready", bus.in_ready, 1);
        end
    endtask

    task automatic txn(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                       input logic o, input logic [2*W-1:0] nexp);
        send(q, d, r, o, nexp);
        collect(LAT, 0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Q         = '0;
        bus.D         = '0;
        bus.R         = '0;
        bus.op        = 1'b0;
        bus.N_exp     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_N", bus.N, 0);
        check("rst_rem_err", bus.rem_err, 0);
        check("rst_mismatch", bus.mismatch, 0);

        txn(32'd7, 32'd9, 32'd4, 1'b0, 64'd67);
        txn(32'd7, 32'd9, 32'd4, 1'b0, 64'd68);
        txn(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 64'hFFFFFFFEFFFFFFFF);
        txn(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFE00000001);
        txn(32'd3, 32'd0, 32'd5, 1'b0, 64'd5);
        txn(32'd3, 32'd0, 32'd5, 1'b1, 64'd0);
        txn(32'd2, 32'd5, 32'd5, 1'b0, 64'd15);
        txn(32'd0, 32'd123, 32'd7, 1'b0, 64'd7);

        // Backpressure: out_ready low for 10 cycles after out_valid
        send(32'd1000, 32'd77, 32'd13, 1'b0, 64'd77013);
        collect(LAT, 10);

        // Busy: a second operand set during MUL must be ignored
        send(32'd12, 32'd11, 32'd3, 1'b0, 64'd135);
        repeat (4) tick();
        bus.Q        = 32'd999;
        bus.D        = 32'd888;
        bus.R        = 32'd777;
        bus.op       = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        collect(-1, 0);

        // Reset at MUL cycle 10 discards the operation in progress
        send(32'd5, 32'd6, 32'd1, 1'b0, 64'd31);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_front());
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_N", bus.N, 0);
        txn(32'd1, 32'd1, 32'd0, 1'b0, 64'd1);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0]   q, d, r;
            logic           o;
            logic [2*W-1:0] ne;
            q  = $urandom;
            d  = (i == 2) ? 32'd0 : $urandom;
            r  = (i % 2 == 0) ? $urandom : $urandom_range(0, 1000);
            o  = 1'(i % 3 == 1);
            ne = model(q, d, r, o, 64'd0).n + 64'(i % 2);
            txn(q, d, r, o, ne);
        end

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
